// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding a single UART TX FIFO.
// A grant is held until last byte, length limit or stall timeout.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_LEN     = 64,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               fifo_full,
  output logic               wr,
  output logic [7:0]         w_data,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               pkt_done,
  output logic               timeout_err,
  output logic               len_err
);

  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYC - 1);
  localparam logic [6:0] LEN_LAST = 7'(MAX_LEN - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   pick;
  logic [6:0]      byte_cnt;
  logic [6:0]      byte_inc;
  logic [SW-1:0]   stall_cnt;
  logic [SW-1:0]   stall_inc;
  logic            xfer;
  logic            any_valid;
  logic            cur_valid;
  logic            cur_last;
  logic [7:0]      cur_data;
  logic            accept;
  logic            stall;
  logic            end_last;
  logic            end_len;
  logic            end_tmo;
  logic            end_any;

  // Search starts just past the previous winner so every requester gets a turn.
  function automatic logic [GW-1:0] rr_pick(
    input logic [N_REQ-1:0] v,
    input logic [GW-1:0]    last
  );
    logic [GW-1:0] p;
    logic          hit;
    int            k;
    p   = last;
    hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(last) + i) % N_REQ;
      if (!hit && v[k[GW-1:0]]) begin
        p   = k[GW-1:0];
        hit = 1'b1;
      end
    end
    return p;
  endfunction

  assign pick      = rr_pick(req_valid, last_grant);
  assign any_valid = |req_valid;
  assign xfer      = (state == XFER);
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign cur_data  = req_data[{grant_id, 3'b000} +: 8];

  assign accept   = xfer & cur_valid & ~fifo_full;
  assign stall    = xfer & ~cur_valid & ~fifo_full;
  assign byte_inc = (&byte_cnt) ? byte_cnt : byte_cnt + 7'd1;
  assign stall_inc = (&stall_cnt) ? stall_cnt : stall_cnt + SW'(1);
  assign end_last = accept & cur_last;
  assign end_len  = accept & ~cur_last & (byte_cnt == LEN_LAST);
  assign end_tmo  = stall & (stall_inc >= STALL_MAX);
  assign end_any  = end_last | end_len | end_tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_valid) state_nxt = XFER;
      XFER: if (end_any)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    wr        = accept;
    w_data    = xfer ? cur_data : 8'h00;
    busy      = xfer;
    if (xfer && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id    <= '0;
      last_grant  <= GW'(N_REQ - 1);
      byte_cnt    <= '0;
      stall_cnt   <= '0;
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      pkt_done    <= end_last;
      timeout_err <= end_tmo;
      len_err     <= end_len;
      if (!xfer) begin
        if (any_valid) begin
          grant_id  <= pick;
          byte_cnt  <= '0;
          stall_cnt <= '0;
        end
      end else begin
        if (accept) begin
          byte_cnt  <= byte_inc;
          stall_cnt <= '0;
        end else if (stall) begin
          stall_cnt <= stall_inc;
        end
        if (end_any) last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes,
// expected FIFO writes and grant order are queued and popped on output.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int ML  = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_full = 1'b0;
  logic          wr;
  logic [7:0]    w_data;
  logic          busy;
  logic [1:0]    grant_id;
  logic          pkt_done;
  logic          timeout_err;
  logic          len_err;

  uart_tx_arbiter #(
    .N_REQ(N),
    .TIMEOUT_CYC(TMO),
    .MAX_LEN(ML)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .wr(wr),
    .w_data(w_data),
    .busy(busy),
    .grant_id(grant_id),
    .pkt_done(pkt_done),
    .timeout_err(timeout_err),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  logic [8:0] src_q[N][$];
  logic [9:0] exp_q[$];
  int         exp_g[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_wr, first_wr, last_wr, start_cyc;
  int n_done, done_cyc, n_tmo, tmo_at, n_len, len_at;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int id, input int base, input int len,
                      input bit end_last);
    logic [7:0] d;
    logic       l;
    for (int k = 0; k < len; k++) begin
      d = 8'(base + k);
      l = end_last && (k == len - 1);
      src_q[id].push_back({l, d});
      exp_q.push_back({2'(id), d});
    end
  endtask

  task automatic clr_mon();
    n_wr = 0; first_wr = 0; last_wr = 0;
    n_done = 0; done_cyc = 0;
    n_tmo = 0; tmo_at = 0;
    n_len = 0; len_at = 0;
  endtask

  // Monitor on the falling edge, driver just after the rising edge.
  initial begin
    logic       busy_q;
    logic [N-1:0] acc;
    logic [N-1:0] prev;
    logic [9:0] e;
    busy_q = 1'b0;
    acc = '0;
    clr_mon();
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_q = 1'b0;
        acc = '0;
      end else begin
        acc = req_valid & req_ready;
        if (wr) begin
          if (n_wr == 0) first_wr = cyc;
          last_wr = cyc;
          n_wr++;
          if (exp_q.size() == 0) chk("wr_unexp", 32'(wr), 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("wr_data", 32'(w_data), 32'(e[7:0]));
            chk("wr_id", 32'(grant_id), 32'(e[9:8]));
          end
        end
        if (fifo_full) begin
          chk("bp_wr", 32'(wr), 32'd0);
          chk("bp_rdy", 32'(req_ready), 32'd0);
        end
        if (busy && !busy_q) begin
          if (exp_g.size() == 0) chk("gnt_unexp", 32'(busy), 32'd0);
          else chk("gnt_id", 32'(grant_id), 32'(exp_g.pop_front()));
        end
        busy_q = busy;
        if (pkt_done) begin
          n_done++; done_cyc = cyc;
          chk("done_busy", 32'(busy), 32'd0);
        end
        if (timeout_err) begin
          n_tmo++; tmo_at = n_wr;
          chk("tmo_busy", 32'(busy), 32'd0);
        end
        if (len_err) begin
          n_len++; len_at = n_wr;
          chk("len_busy", 32'(busy), 32'd0);
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      acc = '0;
      prev = req_valid;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i] = src_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
      if (prev == '0 && req_valid != '0) start_cyc = cyc;
    end
  end

  function automatic bit src_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || src_busy()) && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    chk(tag, 32'(t >= 400), 32'd0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_wr(input int n, input string tag);
    int t;
    t = 0;
    while (n_wr < n && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk(tag, 32'(t >= 200), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_pulse", 32'({pkt_done, timeout_err, len_err}), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    exp_g.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // single packet from requester 2
    clr_mon();
    load(2, 'h30, 10, 1'b1);
    exp_g.push_back(2);
    wait_drain("t1_drain");
    chk("t1_nwr", 32'(n_wr), 32'd10);
    chk("t1_lat", 32'(first_wr - start_cyc), 32'd1);
    chk("t1_consec", 32'(last_wr - first_wr), 32'd9);
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_done_cyc", 32'(done_cyc - last_wr), 32'd1);

    // round robin, two 3-byte packets per requester
    do_reset();
    clr_mon();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        load(i, 'h80 + i * 16 + p * 4, 3, 1'b1);
        exp_g.push_back(i);
      end
    wait_drain("t2_drain");
    chk("t2_nwr", 32'(n_wr), 32'd24);
    chk("t2_done", 32'(n_done), 32'd8);

    // backpressure longer than the stall timeout
    clr_mon();
    load(3, 'h10, 8, 1'b1);
    exp_g.push_back(3);
    wait_wr(3, "t3_wait");
    @(posedge clk);
    #2 fifo_full = 1'b1;
    repeat (10) @(posedge clk);
    #2 fifo_full = 1'b0;
    wait_drain("t3_drain");
    chk("t3_nwr", 32'(n_wr), 32'd8);
    chk("t3_tmo", 32'(n_tmo), 32'd0);
    chk("t3_done", 32'(n_done), 32'd1);

    // requester 0 stalls after 2 bytes, requester 1 follows
    do_reset();
    clr_mon();
    load(0, 'hA0, 2, 1'b0);
    load(1, 'hB0, 3, 1'b1);
    exp_g.push_back(0);
    exp_g.push_back(1);
    wait_drain("t4_drain");
    chk("t4_tmo", 32'(n_tmo), 32'd1);
    chk("t4_tmo_at", 32'(tmo_at), 32'd2);
    chk("t4_done", 32'(n_done), 32'd1);
    chk("t4_nwr", 32'(n_wr), 32'd5);

    // 14-byte packet against a 12-byte limit
    clr_mon();
    load(1, 'h50, 14, 1'b1);
    exp_g.push_back(1);
    exp_g.push_back(1);
    wait_drain("t5_drain");
    chk("t5_len", 32'(n_len), 32'd1);
    chk("t5_len_at", 32'(len_at), 32'(ML));
    chk("t5_done", 32'(n_done), 32'd1);
    chk("t5_nwr", 32'(n_wr), 32'd14);

    // reset mid-packet, then requester 0 wins first
    clr_mon();
    load(1, 'h60, 8, 1'b1);
    exp_g.push_back(1);
    wait_wr(3, "t6_wait");
    do_reset();
    chk("t6_nopulse", 32'(n_done + n_tmo + n_len), 32'd0);
    clr_mon();
    load(0, 'h78, 2, 1'b1);
    load(3, 'h70, 2, 1'b1);
    exp_g.push_back(0);
    exp_g.push_back(3);
    wait_drain("t6_drain");
    chk("t6_done", 32'(n_done), 32'd2);
    chk("t6_nwr", 32'(n_wr), 32'd4);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("gnt_left", 32'(exp_g.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
